// File: rtl/vlsu_txn_splitter_if.sv
// Request and burst channels of the VLSU transaction splitter.
// The slave modport is the splitter's own view; master is the surrounding logic.
interface vlsu_txn_splitter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_bytes;
  logic [3:0]        req_mode;
  logic              req_final;
  logic [ID_W-1:0]   req_id;

  logic              txn_valid;
  logic              txn_ready;
  logic [ADDR_W-1:0] txn_addr;
  logic [7:0]        txn_len;
  logic [LEN_W-1:0]  txn_bytes;
  logic [3:0]        txn_mode;
  logic [ID_W-1:0]   txn_id;
  logic              txn_last;
  logic              txn_final;

  modport slave (
    input  req_valid, req_addr, req_bytes, req_mode, req_final, req_id, txn_ready,
    output req_ready, txn_valid, txn_addr, txn_len, txn_bytes, txn_mode, txn_id,
           txn_last, txn_final
  );

  modport master (
    output req_valid, req_addr, req_bytes, req_mode, req_final, req_id, txn_ready,
    input  req_ready, txn_valid, txn_addr, txn_len, txn_bytes, txn_mode, txn_id,
           txn_last, txn_final
  );
endinterface

// File: rtl/vlsu_txn_splitter.sv
// Cuts one fragment request into bus bursts that never cross a page boundary
// and never exceed MAX_BEATS beats; tags each burst with last/final flags.
module vlsu_txn_splitter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned BUS_BYTES  = 32,
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned PAGE_BYTES = 4096,
  parameter int unsigned ID_W       = 4
) (
  input  logic clock,
  input  logic reset,
  vlsu_txn_splitter_if.slave bus,
  output logic busy,
  output logic err_zero
);
  localparam int unsigned OFF_W       = $clog2(BUS_BYTES);
  localparam int unsigned PG_W        = $clog2(PAGE_BYTES);
  localparam int unsigned BURST_BYTES = MAX_BEATS * BUS_BYTES;
  // Wide enough for both a remaining count and a full page of room.
  localparam int unsigned CW          = (LEN_W > PG_W + 1) ? LEN_W : PG_W + 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rmn;
  logic [3:0]        mode_q;
  logic              final_q;
  logic [ID_W-1:0]   id_q;

  logic [CW-1:0]     off, page_room, burst_room, chunk, span;
  logic              last;
  logic              req_fire, txn_fire;

  assign req_fire = bus.req_valid && bus.req_ready;
  assign txn_fire = bus.txn_valid && bus.txn_ready;

  // Chunk = min(remaining, room to page end, room to the MAX_BEATS beat limit).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    off        = CW'(cur_addr[OFF_W-1:0]);
    page_room  = CW'(PAGE_BYTES) - CW'(cur_addr[PG_W-1:0]);
    burst_room = CW'(BURST_BYTES) - off;
    chunk      = CW'(rmn);
    if (page_room < chunk)  chunk = page_room;
    if (burst_room < chunk) chunk = burst_room;
    // beats-1 == floor((off+chunk-1)/BUS_BYTES) since chunk >= 1 while splitting
    span       = off + chunk - CW'(1);
    last       = (CW'(rmn) == chunk);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_fire && bus.req_bytes != '0) state_nxt = SPLIT;
      SPLIT:   if (txn_fire && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers are reset too, so outputs are deterministic out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr <= '0;
      rmn      <= '0;
      mode_q   <= '0;
      final_q  <= 1'b0;
      id_q     <= '0;
      err_zero <= 1'b0;
    end else begin
      err_zero <= req_fire && (bus.req_bytes == '0);
      if (req_fire) begin
        cur_addr <= bus.req_addr;
        rmn      <= bus.req_bytes;
        mode_q   <= bus.req_mode;
        final_q  <= bus.req_final;
        id_q     <= bus.req_id;
      end else if (txn_fire) begin
        cur_addr <= cur_addr + ADDR_W'(chunk);
        rmn      <= rmn - LEN_W'(chunk);
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.txn_valid = (state == SPLIT);
  assign bus.txn_addr  = cur_addr;
  assign bus.txn_len   = 8'(span >> OFF_W);
  assign bus.txn_bytes = LEN_W'(chunk);
  assign bus.txn_mode  = mode_q;
  assign bus.txn_id    = id_q;
  assign bus.txn_last  = last;
  assign bus.txn_final = last && final_q;
  assign busy          = (state != IDLE);

  a_len_max: assert property (@(posedge clock) disable iff (reset)
    bus.txn_valid |-> (32'(bus.txn_len) < MAX_BEATS));
  a_no_page_cross: assert property (@(posedge clock) disable iff (reset)
    bus.txn_valid |-> (chunk <= page_room));
endmodule

// File: tb/tb_vlsu_txn_splitter.sv
// Randomized and directed bench for vlsu_txn_splitter against a queue-based
// burst model computed from plain address arithmetic.
module tb_vlsu_txn_splitter;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned BUS_BYTES  = 32;
  localparam int unsigned MAX_BEATS  = 16;
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned ID_W       = 4;

  logic clock = 1'b0;
  logic reset;
  logic busy, err_zero;
  int   checks = 0;
  int   errors = 0;

  vlsu_txn_splitter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  vlsu_txn_splitter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BUS_BYTES(BUS_BYTES),
    .MAX_BEATS(MAX_BEATS), .PAGE_BYTES(PAGE_BYTES), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .err_zero(err_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint unsigned addr;
    int unsigned     len;
    int unsigned     bytes;
    bit              last;
    bit              fin;
  } burst_t;

  burst_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walk the request in byte terms: take as much as fits before the next page
  // boundary and the next MAX_BEATS*BUS_BYTES window measured from the bus-aligned start.
  function automatic void build_model(input longint unsigned addr, input int unsigned nbytes,
                                      input bit fin);
    longint unsigned cur = addr;
    int unsigned rem = nbytes;
    exp_q.delete();
    while (rem > 0) begin
      burst_t e;
      int unsigned off = int'(cur % BUS_BYTES);
      int unsigned c   = rem;
      if (PAGE_BYTES - int'(cur % PAGE_BYTES) < c) c = PAGE_BYTES - int'(cur % PAGE_BYTES);
      if (MAX_BEATS * BUS_BYTES - off < c) c = MAX_BEATS * BUS_BYTES - off;
      e.addr  = cur;
      e.bytes = c;
      e.len   = (off + c + BUS_BYTES - 1) / BUS_BYTES - 1;
      e.last  = (rem == c);
      e.fin   = e.last && fin;
      exp_q.push_back(e);
      cur += c;
      rem -= c;
    end
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("req_ready_before_req", bus.req_ready, 1);
  endtask

  task automatic drive_req(input longint unsigned addr, input int unsigned nbytes,
                           input logic [3:0] mode, input bit fin, input logic [3:0] id);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_bytes = nbytes[LEN_W-1:0];
    bus.req_mode  = mode;
    bus.req_final = fin;
    bus.req_id    = id;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  // stall: 0 = ready at once, 1 = five idle cycles per burst, 2 = random 0..3
  task automatic run_req(input longint unsigned addr, input int unsigned nbytes,
                         input logic [3:0] mode, input bit fin, input logic [3:0] id,
                         input int stall);
    longint unsigned sum = 0;
    build_model(addr, nbytes, fin);
    wait_idle();
    bus.txn_ready = 1'b0;
    drive_req(addr, nbytes, mode, fin, id);
    foreach (exp_q[b]) begin
      int wait_n = (stall == 1) ? 5 : (stall == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int w = 0; w <= wait_n; w++) begin
        bus.txn_ready = (w == wait_n);
        check("txn_valid", bus.txn_valid, 1);
        check("req_ready_split", bus.req_ready, 0);
        check("busy_split", busy, 1);
        check("err_zero_quiet", err_zero, 0);
        check("txn_addr", bus.txn_addr, exp_q[b].addr);
        check("txn_len", bus.txn_len, exp_q[b].len);
        check("txn_bytes", bus.txn_bytes, exp_q[b].bytes);
        check("txn_last", bus.txn_last, exp_q[b].last);
        check("txn_final", bus.txn_final, exp_q[b].fin);
        check("txn_mode", bus.txn_mode, mode);
        check("txn_id", bus.txn_id, id);
        if (w == 0) begin
          check("no_page_cross",
                (longint'(bus.txn_addr % PAGE_BYTES) + longint'(bus.txn_bytes)) <= PAGE_BYTES, 1);
          check("len_below_max", 32'(bus.txn_len) < MAX_BEATS, 1);
          sum += bus.txn_bytes;
        end
        @(negedge clock);
      end
    end
    bus.txn_ready = 1'b0;
    check("sum_bytes", sum, nbytes);
    check("txn_valid_after", bus.txn_valid, 0);
    check("req_ready_after", bus.req_ready, 1);
    check("busy_after", busy, 0);
  endtask

  task automatic zero_req();
    wait_idle();
    drive_req({$urandom, $urandom}, 0, 4'b0001, 1'b1, 4'h3);
    check("zero_err_pulse", err_zero, 1);
    check("zero_txn_valid", bus.txn_valid, 0);
    check("zero_req_ready", bus.req_ready, 1);
    check("zero_busy", busy, 0);
    @(negedge clock);
    check("zero_err_clear", err_zero, 0);
    check("zero_txn_valid2", bus.txn_valid, 0);
    check("zero_req_ready2", bus.req_ready, 1);
  endtask

  task automatic reset_mid_req();
    wait_idle();
    bus.txn_ready = 1'b0;
    drive_req(64'h10, 1024, 4'b0100, 1'b1, 4'h9);
    check("rst_txn_valid_before", bus.txn_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_txn_valid", bus.txn_valid, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", busy, 0);
    bus.txn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_no_burst", bus.txn_valid, 0);
    end
    bus.txn_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_bytes = '0;
    bus.req_mode  = '0;
    bus.req_final = 1'b0;
    bus.req_id    = '0;
    bus.txn_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_txn_valid", bus.txn_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err_zero", err_zero, 0);
    check("reset_txn_addr", bus.txn_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    run_req(64'h0,   64,   4'b0001, 1'b0, 4'h1, 0);
    run_req(64'hFF0, 64,   4'b0001, 1'b0, 4'h2, 0);
    run_req(64'h10,  1024, 4'b0010, 1'b0, 4'h3, 0);
    run_req(64'h10,  1024, 4'b0100, 1'b1, 4'h4, 1);
    run_req(64'hFF0, 64,   4'b1000, 1'b1, 4'h5, 0);
    run_req(64'hFFFF_FFFF_FFFF_FFF0, 64, 4'b0001, 1'b1, 4'h6, 2);
    run_req(64'h1F, 1, 4'b0001, 1'b0, 4'h7, 0);
    zero_req();
    reset_mid_req();
    run_req(64'h2000, 512, 4'b0001, 1'b1, 4'h8, 2);

    for (int i = 0; i < 40; i++) begin
      longint unsigned a = {$urandom, $urandom};
      if (i % 3 == 0) a = (a & ~64'hFFF) | longint'(PAGE_BYTES - $urandom_range(1, 64));
      run_req(a, $urandom_range(1, 3000), 4'b0001 << $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 4'($urandom), 2);
      if (i % 10 == 9) zero_req();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
